ray_box_dispatcher: RTL

//  Drives the box-intersection tracer for one ray at a time.
//  - Latches a ray (init/dir).
//  - Walks the object table, presenting each 56-bit box to the tracer.
//  - Waits out the tracer latency, then samples t/normal and keeps the nearest hit.
//  - Returns the nearest hit over a valid/ready handshake to the shading stage.

---
 rtl/ray_pkg.sv | 26 ++
 rtl/ray_hit_min.sv | 66 ++++++
 rtl/ray_box_dispatcher.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/ray_pkg.sv
// Shared widths, miss encoding and FSM state encoding for the ray/box dispatcher.
package ray_pkg;

    localparam int INIT_W = 28;
    localparam int DIR_W  = 31;
    localparam int OBJ_W  = 56;
    localparam int T_W    = 10;
    localparam int N_W    = 31;

    localparam logic [T_W-1:0] MISS_T = 10'h3FF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CMP   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Strictly closer: equal distances keep the earlier (lower-index) hit.
    function automatic logic t_closer(input logic [T_W-1:0] cand, input logic [T_W-1:0] best);
        return (cand < best);
    endfunction

endpackage

// File: rtl/ray_hit_min.sv
// Registered nearest-hit keeper: clear to "no hit", update on a strictly smaller distance.
module ray_hit_min
    import ray_pkg::*;
#(
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            upd_en,
    input  logic [T_W-1:0]  cand_t,
    input  logic [N_W-1:0]  cand_n,
    input  logic [ID_W-1:0] cand_id,
    output logic [T_W-1:0]  best_t,
    output logic [N_W-1:0]  best_n,
    output logic [ID_W-1:0] best_id,
    output logic            best_any
);

    logic [T_W-1:0]  best_t_q,   best_t_d;
    logic [N_W-1:0]  best_n_q,   best_n_d;
    logic [ID_W-1:0] best_id_q,  best_id_d;
    logic            best_any_q, best_any_d;

    // Next keeper contents; a miss can never win since the cleared distance is MISS_T.
    always_comb begin
        best_t_d   = best_t_q;
        best_n_d   = best_n_q;
        best_id_d  = best_id_q;
        best_any_d = best_any_q;
        if (clear) begin
            best_t_d   = MISS_T;
            best_n_d   = {N_W{1'b0}};
            best_id_d  = {ID_W{1'b0}};
            best_any_d = 1'b0;
        end else if (upd_en && t_closer(cand_t, best_t_q)) begin
            best_t_d   = cand_t;
            best_n_d   = cand_n;
            best_id_d  = cand_id;
            best_any_d = 1'b1;
        end else begin
            best_any_d = best_any_q;
        end
    end

    // Keeper registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            best_t_q   <= {T_W{1'b0}};
            best_n_q   <= {N_W{1'b0}};
            best_id_q  <= {ID_W{1'b0}};
            best_any_q <= 1'b0;
        end else begin
            best_t_q   <= best_t_d;
            best_n_q   <= best_n_d;
            best_id_q  <= best_id_d;
            best_any_q <= best_any_d;
        end
    end

    assign best_t   = best_t_q;
    assign best_n   = best_n_q;
    assign best_id  = best_id_q;
    assign best_any = best_any_q;

endmodule

// File: rtl/ray_box_dispatcher.sv
// Walks the object table for one ray, feeds each box to the tracer and returns the nearest hit.
// Optional cycle counter output hit_cycles is enabled by defining DISPATCH_CYCLE_CNT_EN.
module ray_box_dispatcher
    import ray_pkg::*;
#(
    parameter int NUM_OBJECTS    = 8,
    parameter int TRACER_LATENCY = 4,
    parameter int ID_W           = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ray_valid,
    output logic              ray_ready,
    input  logic [INIT_W-1:0] ray_init,
    input  logic [DIR_W-1:0]  ray_dir,
    output logic              obj_rd_en,
    output logic [ID_W-1:0]   obj_addr,
    input  logic [OBJ_W-1:0]  obj_data,
    output logic [INIT_W-1:0] trc_init,
    output logic [DIR_W-1:0]  trc_dir,
    output logic [OBJ_W-1:0]  trc_object,
    input  logic [T_W-1:0]    trc_t,
    input  logic [N_W-1:0]    trc_normal,
    output logic              hit_valid,
    input  logic              hit_ready,
    output logic [T_W-1:0]    hit_t,
    output logic [N_W-1:0]    hit_normal,
    output logic [ID_W-1:0]   hit_id,
    output logic              hit_any
`ifdef DISPATCH_CYCLE_CNT_EN
    ,
    output logic [15:0]       hit_cycles
`endif
);

    localparam int WC_W = (TRACER_LATENCY > 1) ? $clog2(TRACER_LATENCY) : 1;
    localparam logic [WC_W-1:0] WAIT_INIT = WC_W'(TRACER_LATENCY - 1);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_OBJECTS - 1);

    state_e            state_q, state_d;
    logic [INIT_W-1:0] trc_init_q, trc_init_d;
    logic [DIR_W-1:0]  trc_dir_q,  trc_dir_d;
    logic [OBJ_W-1:0]  trc_obj_q,  trc_obj_d;
    logic [ID_W-1:0]   idx_q,      idx_d;
    logic [WC_W-1:0]   wait_q,     wait_d;

    logic accept_s;
    logic clear_s;
    logic upd_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ray_valid) state_d = ST_FETCH;
                else           state_d = ST_IDLE;
            end
            ST_FETCH: state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_q == {WC_W{1'b0}}) state_d = ST_CMP;
                else                        state_d = ST_WAIT;
            end
            ST_CMP: begin
                if (idx_q == LAST_IDX) state_d = ST_DONE;
                else                   state_d = ST_FETCH;
            end
            ST_DONE: begin
                if (hit_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs and datapath enables.
    always_comb begin
        ray_ready = 1'b0;
        obj_rd_en = 1'b0;
        hit_valid = 1'b0;
        upd_s     = 1'b0;
        case (state_q)
            ST_IDLE:  ray_ready = 1'b1;
            ST_FETCH: obj_rd_en = 1'b1;
            ST_CMP:   upd_s     = 1'b1;
            ST_DONE:  hit_valid = 1'b1;
            default: begin
                ray_ready = 1'b0;
                obj_rd_en = 1'b0;
                hit_valid = 1'b0;
                upd_s     = 1'b0;
            end
        endcase
        accept_s = ray_ready & ray_valid;
        clear_s  = accept_s;
    end

    // Datapath next values; ray inputs only matter on accept, trc_* otherwise hold.
    always_comb begin
        trc_init_d = trc_init_q;
        trc_dir_d  = trc_dir_q;
        trc_obj_d  = trc_obj_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        if (accept_s) begin
            trc_init_d = ray_init;
            trc_dir_d  = ray_dir;
            idx_d      = {ID_W{1'b0}};
        end else if (state_q == ST_CMP && idx_q != LAST_IDX) begin
            idx_d = idx_q + ID_W'(1);
        end else begin
            idx_d = idx_q;
        end
        if (state_q == ST_LOAD) begin
            trc_obj_d = obj_data;
            wait_d    = WAIT_INIT;
        end else if (state_q == ST_WAIT && wait_q != {WC_W{1'b0}}) begin
            wait_d = wait_q - WC_W'(1);
        end else begin
            wait_d = wait_q;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            trc_init_q <= {INIT_W{1'b0}};
            trc_dir_q  <= {DIR_W{1'b0}};
            trc_obj_q  <= {OBJ_W{1'b0}};
            idx_q      <= {ID_W{1'b0}};
            wait_q     <= {WC_W{1'b0}};
        end else begin
            trc_init_q <= trc_init_d;
            trc_dir_q  <= trc_dir_d;
            trc_obj_q  <= trc_obj_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
        end
    end

    ray_hit_min #(
        .ID_W (ID_W)
    ) u_hit_min (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .upd_en   (upd_s),
        .cand_t   (trc_t),
        .cand_n   (trc_normal),
        .cand_id  (idx_q),
        .best_t   (hit_t),
        .best_n   (hit_normal),
        .best_id  (hit_id),
        .best_any (hit_any)
    );

    assign obj_addr   = idx_q;
    assign trc_init   = trc_init_q;
    assign trc_dir    = trc_dir_q;
    assign trc_object = trc_obj_q;

`ifdef DISPATCH_CYCLE_CNT_EN
    logic [15:0] cyc_q, cyc_d;
    logic        busy_s;

    // Starts at 1 on accept so the DONE cycle reads the full handshake-to-valid distance.
    always_comb begin
        busy_s = (state_q == ST_FETCH) || (state_q == ST_LOAD) ||
                 (state_q == ST_WAIT)  || (state_q == ST_CMP);
        cyc_d  = cyc_q;
        if (accept_s) begin
            cyc_d = 16'd1;
        end else if (busy_s && cyc_q != 16'hFFFF) begin
            cyc_d = cyc_q + 16'd1;
        end else begin
            cyc_d = cyc_q;
        end
    end

    // Cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q <= 16'd0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign hit_cycles = cyc_q;
`endif

endmodule
